// File: rtl/edge_pulse_gen_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : edge_pulse_gen_mc_if
//  Description : Control/status bundle for the multi-channel edge-to-pulse
//                generator. The master drives the raw inputs and settings;
//                the slave (the generator) returns pulses, levels and
//                overrun flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface edge_pulse_gen_mc_if #(
  parameter int CH      = 4,
  parameter int DEB_W   = 4,
  parameter int PULSE_W = 8
);
  logic                en;
  logic [CH-1:0]       sig_in;
  logic [2*CH-1:0]     edge_mode;
  logic [DEB_W-1:0]    deb_len;
  logic [PULSE_W-1:0]  pulse_len;
  logic                clr_overrun;
  logic [CH-1:0]       pulse;
  logic [CH-1:0]       lvl;
  logic [CH-1:0]       overrun;

  modport master (
    output en, sig_in, edge_mode, deb_len, pulse_len, clr_overrun,
    input  pulse, lvl, overrun
  );

  modport slave (
    input  en, sig_in, edge_mode, deb_len, pulse_len, clr_overrun,
    output pulse, lvl, overrun
  );
endinterface
`default_nettype wire

// File: rtl/edge_pulse_gen_mc.sv
`default_nettype none
// ============================================================================
//  Module      : edge_pulse_gen_mc
//  Description : Multi-channel edge-to-pulse generator. Each channel has a
//                synchroniser, a debounce filter, edge-mode qualification and
//                a retriggerable stretched pulse with sticky overrun flag.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_pulse_gen_mc #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4,
  parameter int PULSE_W     = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  edge_pulse_gen_mc_if.slave bus
);

  localparam int c_PRIME_W = $clog2(SYNC_STAGES + 1);

  logic [c_PRIME_W-1:0]              r_prime;
  logic                              w_priming;
  logic [SYNC_STAGES-1:0][CH-1:0]    r_sync;
  logic [CH-1:0]                     w_sync_out;
  logic [CH-1:0]                     w_sync_next;
  logic [PULSE_W-1:0]                w_load_val;
  logic [CH-1:0]                     w_pulse;
  logic [CH-1:0]                     w_lvl;
  logic [CH-1:0]                     w_overrun;

  assign w_priming   = (r_prime != '0);
  assign w_sync_out  = r_sync[SYNC_STAGES-1];
  // Value the last sync stage is about to take; during priming lvl follows it
  // so that lvl and sync_out agree the moment the prime window closes.
  assign w_sync_next = r_sync[SYNC_STAGES-2];
  assign w_load_val  = (bus.pulse_len == '0) ? PULSE_W'(1) : bus.pulse_len;

  // Prime window: counts down SYNC_STAGES edges after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prime <= c_PRIME_W'(SYNC_STAGES);
    end else if (r_prime != '0) begin
      r_prime <= r_prime - 1'b1;
    end
  end

  // Synchroniser chain for all channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= bus.sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DEB_W-1:0]   r_deb_cnt;
    logic               r_lvl;
    logic [PULSE_W-1:0] r_pcnt;
    logic               r_ovr;
    logic               w_mismatch;
    logic               w_accept;
    logic [1:0]         w_mode;
    logic               w_valid;

    assign w_mismatch = (w_sync_out[i] != r_lvl);
    assign w_accept   = !w_priming && w_mismatch && (r_deb_cnt == bus.deb_len);
    assign w_mode     = bus.edge_mode[2*i +: 2];
    // New level 1 means a rising edge, new level 0 a falling edge.
    assign w_valid    = w_accept && bus.en &&
                        ((w_sync_out[i] && w_mode[0]) || (!w_sync_out[i] && w_mode[1]));

    // Debounce filter: a mismatch must persist deb_len extra cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lvl     <= 1'b0;
        r_deb_cnt <= '0;
      end else if (w_priming) begin
        r_lvl     <= w_sync_next[i];
        r_deb_cnt <= '0;
      end else if (!w_mismatch) begin
        r_deb_cnt <= '0;
      end else if (w_accept) begin
        r_lvl     <= w_sync_out[i];
        r_deb_cnt <= '0;
      end else if (r_deb_cnt != '1) begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end

    // Pulse stretcher: load on a qualified edge, count down otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pcnt <= '0;
      end else if (!bus.en) begin
        r_pcnt <= '0;
      end else if (w_valid) begin
        r_pcnt <= w_load_val;
      end else if (r_pcnt != '0) begin
        r_pcnt <= r_pcnt - 1'b1;
      end
    end

    // Sticky overrun: a retrigger sets it, and a set beats a clear.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ovr <= 1'b0;
      end else begin
        r_ovr <= (r_ovr && !bus.clr_overrun) || (w_valid && (r_pcnt != '0));
      end
    end

    assign w_pulse[i]   = (r_pcnt != '0);
    assign w_lvl[i]     = r_lvl;
    assign w_overrun[i] = r_ovr;
  end

  assign bus.pulse   = w_pulse;
  assign bus.lvl     = w_lvl;
  assign bus.overrun = w_overrun;

endmodule
`default_nettype wire

// File: tb/tb_edge_pulse_gen_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_pulse_gen_mc
//  Description : Directed self-checking bench for edge_pulse_gen_mc.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_edge_pulse_gen_mc;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  edge_pulse_gen_mc_if #(.CH(4), .DEB_W(4), .PULSE_W(8)) bus_if ();

  edge_pulse_gen_mc #(
    .CH(4), .SYNC_STAGES(2), .DEB_W(4), .PULSE_W(8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus_if.en          = 1'b1;
    bus_if.sig_in      = 4'h0;
    bus_if.edge_mode   = 8'h2D;   // ch3=00 ch2=10 ch1=11 ch0=01
    bus_if.deb_len     = 4'd3;
    bus_if.pulse_len   = 8'd5;
    bus_if.clr_overrun = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_val("reset pulse",   bus_if.pulse,   4'h0);
    check_val("reset lvl",     bus_if.lvl,     4'h0);
    check_val("reset overrun", bus_if.overrun, 4'h0);
    tick();
    rst = 1'b0;
    idle(6);

    // 1: rising edge, deb 3, pulse 5 -> pulse on edges 5..9
    for (int k = 0; k < 12; k++) begin
      bus_if.sig_in = 4'h1;
      tick();
      check_val($sformatf("t1 pulse k=%0d", k), bus_if.pulse, (k >= 5 && k <= 9) ? 4'h1 : 4'h0);
      check_val($sformatf("t1 lvl k=%0d", k),   bus_if.lvl,   (k >= 5) ? 4'h1 : 4'h0);
    end
    check_val("t1 overrun", bus_if.overrun, 4'h0);
    bus_if.sig_in = 4'h0;
    idle(10);
    check_val("t1 lvl back low", bus_if.lvl, 4'h0);

    // 2a: 3-cycle glitch is rejected
    for (int k = 0; k < 16; k++) begin
      bus_if.sig_in = (k < 3) ? 4'h1 : 4'h0;
      tick();
      check_val($sformatf("t2a pulse k=%0d", k), bus_if.pulse, 4'h0);
      check_val($sformatf("t2a lvl k=%0d", k),   bus_if.lvl,   4'h0);
    end
    // 2b: 4-cycle high is accepted; falling edge ignored in rise mode
    for (int k = 0; k < 16; k++) begin
      bus_if.sig_in = (k < 4) ? 4'h1 : 4'h0;
      tick();
      check_val($sformatf("t2b pulse k=%0d", k), bus_if.pulse, (k >= 5 && k <= 9) ? 4'h1 : 4'h0);
      check_val($sformatf("t2b lvl k=%0d", k),   bus_if.lvl,   (k >= 5 && k <= 8) ? 4'h1 : 4'h0);
    end

    // 3: modes; all rise at 0, fall at 20
    for (int k = 0; k < 35; k++) begin
      logic [3:0] exp_p;
      bus_if.sig_in = (k < 20) ? 4'hF : 4'h0;
      tick();
      exp_p = 4'h0;
      if (k >= 5 && k <= 9)   exp_p = 4'b0011;
      if (k >= 25 && k <= 29) exp_p = 4'b0110;
      check_val($sformatf("t3 pulse k=%0d", k), bus_if.pulse, exp_p);
      check_val($sformatf("t3 lvl k=%0d", k),   bus_if.lvl,   (k >= 5 && k < 25) ? 4'hF : 4'h0);
    end

    // 4: retrigger, deb 0, pulse 10, ch0 both; toggles at 0,4,8,12,16
    bus_if.deb_len   = 4'd0;
    bus_if.pulse_len = 8'd10;
    bus_if.edge_mode = 8'h2F;
    for (int k = 0; k < 31; k++) begin
      bus_if.sig_in = ((k >= 16) || ((k / 4) % 2 == 0)) ? 4'h1 : 4'h0;
      tick();
      check_val($sformatf("t4 pulse k=%0d", k),   bus_if.pulse,   (k >= 2 && k <= 27) ? 4'h1 : 4'h0);
      check_val($sformatf("t4 overrun k=%0d", k), bus_if.overrun, (k >= 6) ? 4'h1 : 4'h0);
    end
    bus_if.clr_overrun = 1'b1;
    tick();
    bus_if.clr_overrun = 1'b0;
    check_val("t4 clr overrun", bus_if.overrun, 4'h0);
    tick();
    check_val("t4 overrun stays clear", bus_if.overrun, 4'h0);
    // clear coincident with a retrigger at edge 6
    for (int k = 0; k < 9; k++) begin
      bus_if.sig_in      = (k < 4) ? 4'h0 : 4'h1;
      bus_if.clr_overrun = (k == 6);
      tick();
      if (k == 5) check_val("t4 pre-coincident overrun", bus_if.overrun, 4'h0);
      if (k == 6) check_val("t4 set beats clear", bus_if.overrun, 4'h1);
    end
    bus_if.clr_overrun = 1'b1;
    tick();
    bus_if.clr_overrun = 1'b0;
    idle(12);

    // 7: pulse_len 0 -> single-cycle pulse
    bus_if.pulse_len = 8'd0;
    for (int k = 0; k < 5; k++) begin
      bus_if.sig_in = 4'h0;
      tick();
      check_val($sformatf("t7 pulse k=%0d", k), bus_if.pulse, (k == 2) ? 4'h1 : 4'h0);
    end

    // 6a: en dropped mid-pulse; later edge with en=0 moves lvl only
    bus_if.pulse_len = 8'd10;
    for (int k = 0; k < 15; k++) begin
      bus_if.sig_in = (k < 8) ? 4'h1 : 4'h0;
      bus_if.en     = (k < 4);
      tick();
      check_val($sformatf("t6 pulse k=%0d", k), bus_if.pulse, (k >= 2 && k <= 3) ? 4'h1 : 4'h0);
      check_val($sformatf("t6 lvl k=%0d", k),   bus_if.lvl,   (k >= 2 && k < 10) ? 4'h1 : 4'h0);
    end
    bus_if.en = 1'b1;

    // 6b: reset during active pulse with overrun set
    for (int k = 0; k < 7; k++) begin
      bus_if.sig_in = (k < 3) ? 4'h1 : 4'h0;
      tick();
    end
    check_val("t6 pre-reset pulse",   bus_if.pulse,   4'h1);
    check_val("t6 pre-reset overrun", bus_if.overrun, 4'h1);
    #2 rst = 1'b1;
    #1;
    check_val("t6 async pulse drop", bus_if.pulse,   4'h0);
    check_val("t6 async overrun",    bus_if.overrun, 4'h0);

    // 5: input high across reset never pulses
    bus_if.edge_mode = 8'hFF;
    bus_if.sig_in    = 4'hF;
    idle(2);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_val($sformatf("t5 pulse k=%0d", k), bus_if.pulse, 4'h0);
      if (k >= 1) check_val($sformatf("t5 lvl k=%0d", k), bus_if.lvl, 4'hF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
